esm_issue_scheduler: RTL and testbench

Consumer side of the ESM dependency-analysis path. It tracks the life of every instruction-buffer slot (free, waiting, issued) and selects one waiting slot whose dependencies are resolved, as reported on `ready_index`. It hands that slot to the execution side over a valid/ready handshake, then frees the slot on completion. It also returns a one-cycle retire notification so the dependency tables can release dependents. It sits between the IDT (`ready_index` producer) and the execution front end.

---
 rtl/esm_issue_scheduler.sv | 119 +++++++++++
 tb/tb_esm_issue_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esm_issue_scheduler.sv
// ESM issue scheduler: per-slot FREE/WAIT/ISSUED tracking, round-robin
// selection of dependency-resolved slots, issue handshake and retire pulse.
module esm_issue_scheduler #(
    parameter int bs = 16,
    localparam int IW = $clog2(bs)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [bs-1:0] ready_index,
    input  logic          alloc_valid,
    input  logic [IW-1:0] alloc_index,
    output logic          issue_valid,
    output logic [IW-1:0] issue_index,
    input  logic          issue_ready,
    input  logic          complete_valid,
    input  logic [IW-1:0] complete_index,
    output logic          retire_valid,
    output logic [IW-1:0] retire_index,
    output logic [IW:0]   free_count,
    output logic          full,
    output logic          alloc_err,
    output logic          cmpl_err
);

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        WAIT   = 2'b01,
        ISSUED = 2'b10
    } slot_t;

    slot_t         slot_q [bs];
    logic [IW-1:0] rr_ptr;
    logic [IW:0]   free_q;

    logic          hs;
    logic          cmpl_ok;
    logic          alloc_ok;
    logic [bs-1:0] cand;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [IW-1:0] probe;

    always_comb begin
        hs       = issue_valid && issue_ready;
        cmpl_ok  = complete_valid && (slot_q[complete_index] == ISSUED);
        // A same-cycle completion frees the slot before the allocation lands
        alloc_ok = alloc_valid &&
                   ((slot_q[alloc_index] == FREE) ||
                    (cmpl_ok && (complete_index == alloc_index)));

        for (int i = 0; i < bs; i++) begin
            cand[i] = (slot_q[i] == WAIT) && ready_index[i] &&
                      !(issue_valid && (issue_index == IW'(i)));
        end

        sel_found = 1'b0;
        sel_idx   = '0;
        probe     = '0;
        for (int k = 0; k < bs; k++) begin
            probe = rr_ptr + IW'(k);
            if (!sel_found && cand[probe]) begin
                sel_found = 1'b1;
                sel_idx   = probe;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < bs; i++) begin
                slot_q[i] <= FREE;
            end
            rr_ptr       <= '0;
            issue_valid  <= 1'b0;
            issue_index  <= '0;
            retire_valid <= 1'b0;
            retire_index <= '0;
            free_q       <= (IW+1)'(bs);
            alloc_err    <= 1'b0;
            cmpl_err     <= 1'b0;
        end else begin
            if (hs) begin
                slot_q[issue_index] <= ISSUED;
                rr_ptr              <= issue_index + IW'(1);
            end
            if (cmpl_ok) begin
                slot_q[complete_index] <= FREE;
            end
            if (alloc_ok) begin
                slot_q[alloc_index] <= WAIT;
            end

            retire_valid <= cmpl_ok;
            if (cmpl_ok) begin
                retire_index <= complete_index;
            end

            if (!issue_valid || hs) begin
                issue_valid <= sel_found;
                if (sel_found) begin
                    issue_index <= sel_idx;
                end
            end

            case ({cmpl_ok, alloc_ok})
                2'b10:   free_q <= free_q + (IW+1)'(1);
                2'b01:   free_q <= free_q - (IW+1)'(1);
                default: free_q <= free_q;
            endcase

            alloc_err <= alloc_err | (alloc_valid & ~alloc_ok);
            cmpl_err  <= cmpl_err | (complete_valid & ~cmpl_ok);
        end
    end

    assign free_count = free_q;
    assign full       = (free_q == '0);

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Bench for esm_issue_scheduler: directed scenarios plus random traffic,
// scored against a slot-level reference model through expectation queues.
module tb_esm_issue_scheduler;

    localparam int BS = 16;
    localparam int IW = 4;

    logic          clk;
    logic          rst;
    logic [BS-1:0] ready_index;
    logic          alloc_valid;
    logic [IW-1:0] alloc_index;
    logic          issue_valid;
    logic [IW-1:0] issue_index;
    logic          issue_ready;
    logic          complete_valid;
    logic [IW-1:0] complete_index;
    logic          retire_valid;
    logic [IW-1:0] retire_index;
    logic [IW:0]   free_count;
    logic          full;
    logic          alloc_err;
    logic          cmpl_err;

    esm_issue_scheduler #(.bs(BS)) dut (
        .clk            (clk),
        .rst            (rst),
        .ready_index    (ready_index),
        .alloc_valid    (alloc_valid),
        .alloc_index    (alloc_index),
        .issue_valid    (issue_valid),
        .issue_index    (issue_index),
        .issue_ready    (issue_ready),
        .complete_valid (complete_valid),
        .complete_index (complete_index),
        .retire_valid   (retire_valid),
        .retire_index   (retire_index),
        .free_count     (free_count),
        .full           (full),
        .alloc_err      (alloc_err),
        .cmpl_err       (cmpl_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got event with no expectation at %0t", name, $time);
    endtask

    // Reference model: slot life cycle kept as plain arrays and queues
    typedef enum int {S_EMPTY, S_PENDING, S_RUNNING} mslot_t;
    mslot_t m_st [BS];
    int     m_rr = 0;
    bit     m_iv = 0;
    int     m_ii = 0;
    bit     m_aerr = 0;
    bit     m_cerr = 0;
    int     exp_iss[$];
    int     exp_ret[$];

    initial begin
        for (int i = 0; i < BS; i++) m_st[i] = S_EMPTY;
    end

    function automatic int m_free();
        int c = 0;
        for (int i = 0; i < BS; i++) if (m_st[i] == S_EMPTY) c++;
        return c;
    endfunction

    task automatic model_edge();
        mslot_t nst [BS];
        bit hs, found, cok;
        int sel, s, ci, ai;
        if (rst) begin
            for (int i = 0; i < BS; i++) m_st[i] = S_EMPTY;
            m_rr = 0; m_iv = 0; m_ii = 0; m_aerr = 0; m_cerr = 0;
            exp_iss.delete();
            exp_ret.delete();
            return;
        end
        hs = m_iv && issue_ready;
        found = 0;
        sel = 0;
        for (int k = 0; k < BS; k++) begin
            s = (m_rr + k) % BS;
            if (!found && m_st[s] == S_PENDING && ready_index[s] &&
                !(m_iv && m_ii == s)) begin
                found = 1;
                sel = s;
            end
        end
        for (int i = 0; i < BS; i++) nst[i] = m_st[i];
        if (hs) begin
            nst[m_ii] = S_RUNNING;
            m_rr = (m_ii + 1) % BS;
        end
        ci = int'(complete_index);
        cok = complete_valid && m_st[ci] == S_RUNNING;
        if (cok) begin
            nst[ci] = S_EMPTY;
            exp_ret.push_back(ci);
        end else if (complete_valid) begin
            m_cerr = 1;
        end
        ai = int'(alloc_index);
        if (alloc_valid) begin
            if (nst[ai] == S_EMPTY) nst[ai] = S_PENDING;
            else m_aerr = 1;
        end
        if (!m_iv || hs) begin
            m_iv = found;
            if (found) begin
                m_ii = sel;
                exp_iss.push_back(sel);
            end
        end
        for (int i = 0; i < BS; i++) m_st[i] = nst[i];
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    // Monitor: compares DUT outputs against model between edges
    initial forever begin
        int e;
        @(negedge clk);
        check("issue_valid", {31'd0, issue_valid}, {31'd0, m_iv});
        if (issue_valid) begin
            if (exp_iss.size() == 0) fail_now("issue_index");
            else check("issue_index", 32'(issue_index), 32'(exp_iss[0]));
            if (issue_ready && exp_iss.size() > 0) void'(exp_iss.pop_front());
        end
        if (exp_ret.size() > 0) begin
            e = exp_ret.pop_front();
            check("retire_valid", {31'd0, retire_valid}, 32'd1);
            check("retire_index", 32'(retire_index), 32'(e));
        end else begin
            check("retire_valid", {31'd0, retire_valid}, 32'd0);
        end
        check("free_count", 32'(free_count), 32'(m_free()));
        check("full", {31'd0, full}, {31'd0, m_free() == 0});
        check("alloc_err", {31'd0, alloc_err}, {31'd0, m_aerr});
        check("cmpl_err", {31'd0, cmpl_err}, {31'd0, m_cerr});
    end

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_valid = 1'b0;
        complete_valid = 1'b0;
    endtask

    task automatic do_alloc(input int idx);
        alloc_valid = 1'b1;
        alloc_index = IW'(idx);
    endtask

    task automatic do_complete(input int idx);
        complete_valid = 1'b1;
        complete_index = IW'(idx);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Issue everything pending and complete everything running
    task automatic drain();
        bit busy;
        ready_index = '1;
        issue_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            busy = 0;
            for (int i = 0; i < BS; i++) begin
                if (m_st[i] != S_EMPTY) busy = 1;
                if (!complete_valid && m_st[i] == S_RUNNING) do_complete(i);
            end
            if (!busy) break;
            tick();
        end
    endtask

    function automatic int pick(input mslot_t want);
        int c[$];
        for (int i = 0; i < BS; i++) if (m_st[i] == want) c.push_back(i);
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    initial begin
        int p;
        rst = 1'b1;
        ready_index = '0;
        alloc_valid = 1'b0;
        alloc_index = '0;
        issue_ready = 1'b0;
        complete_valid = 1'b0;
        complete_index = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_free_count", 32'(free_count), 32'd16);
        check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);

        // single slot: alloc 3, issue two cycles later, complete, retire
        ready_index = 16'h0008;
        issue_ready = 1'b1;
        do_alloc(3);
        tick();
        tick();
        check("t1_issue_valid", {31'd0, issue_valid}, 32'd1);
        check("t1_issue_index", 32'(issue_index), 32'd3);
        tick();
        do_complete(3);
        tick();
        check("t1_retire_valid", {31'd0, retire_valid}, 32'd1);
        check("t1_retire_index", 32'(retire_index), 32'd3);
        check("t1_free_count", 32'(free_count), 32'd16);

        // back-to-back 0, 5, 9 then re-alloc 0, 5 with rr_ptr at 10
        ready_index = '1;
        do_alloc(0); tick();
        do_alloc(5); tick();
        do_alloc(9); tick();
        repeat (3) tick();
        drain();
        do_alloc(0); tick();
        do_alloc(5); tick();
        repeat (3) tick();
        drain();

        // offer held while not accepted and ready drops
        ready_index = 16'h0080;
        issue_ready = 1'b0;
        do_alloc(7);
        tick();
        tick();
        ready_index = '0;
        for (int c = 0; c < 4; c++) begin
            check("t3_hold_valid", {31'd0, issue_valid}, 32'd1);
            check("t3_hold_index", 32'(issue_index), 32'd7);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        drain();

        // fill every slot, then over-allocate
        ready_index = '0;
        issue_ready = 1'b0;
        for (int i = 0; i < BS; i++) begin
            do_alloc(i);
            tick();
        end
        check("t4_full", {31'd0, full}, 32'd1);
        check("t4_free_count", 32'(free_count), 32'd0);
        do_alloc(2);
        tick();
        check("t4_alloc_err", {31'd0, alloc_err}, 32'd1);
        check("t4_free_after_err", 32'(free_count), 32'd0);
        do_reset();

        // same-cycle complete and alloc of slot 4
        ready_index = 16'h0010;
        issue_ready = 1'b1;
        do_alloc(4);
        tick();
        tick();
        tick();
        ready_index = '0;
        check("t5_before_free", 32'(free_count), 32'd15);
        do_complete(4);
        do_alloc(4);
        tick();
        check("t5_retire_valid", {31'd0, retire_valid}, 32'd1);
        check("t5_retire_index", 32'(retire_index), 32'd4);
        check("t5_free_count", 32'(free_count), 32'd15);
        check("t5_alloc_err", {31'd0, alloc_err}, 32'd0);
        check("t5_cmpl_err", {31'd0, cmpl_err}, 32'd0);
        drain();

        // completion of a free slot, then reset with slots in flight
        do_complete(6);
        tick();
        check("t6_cmpl_err", {31'd0, cmpl_err}, 32'd1);
        check("t6_no_retire", {31'd0, retire_valid}, 32'd0);
        ready_index = '1;
        issue_ready = 1'b1;
        do_alloc(10); tick();
        do_alloc(11); tick();
        do_alloc(12); tick();
        repeat (3) tick();
        ready_index = '0;
        do_reset();
        check("t6_rst_issue_valid", {31'd0, issue_valid}, 32'd0);
        check("t6_rst_issue_index", 32'(issue_index), 32'd0);
        check("t6_rst_retire_valid", {31'd0, retire_valid}, 32'd0);
        check("t6_rst_retire_index", 32'(retire_index), 32'd0);
        check("t6_rst_free_count", 32'(free_count), 32'd16);
        check("t6_rst_full", {31'd0, full}, 32'd0);
        check("t6_rst_errs", {30'd0, alloc_err, cmpl_err}, 32'd0);

        // random traffic
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            ready_index = BS'($urandom);
            issue_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                p = pick(S_EMPTY);
                if (p < 0 || $urandom_range(0, 9) == 0) p = $urandom_range(0, BS - 1);
                do_alloc(p);
            end
            if ($urandom_range(0, 2) == 0) begin
                p = pick(S_RUNNING);
                if (p < 0 || $urandom_range(0, 9) == 0) p = $urandom_range(0, BS - 1);
                do_complete(p);
            end
            tick();
        end
        rst = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
